// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - Coprocessor-0: Status/Cause/EPC/PRId, exception/interrupt/ERET redirect
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Unimpl, Sys, Eret        commit-point events, qualified by InstrValid
//   InstrValid               commit slot holds a real instruction
//   ExcPCIn                  PC of the committing instruction
//   CPWr/CPWAddr/CPWData     MTC0 write port
//   CPRAddr/CPRData          MFC0 combinational read port
//   HWInt                    asynchronous external interrupt lines
//   Redirect/RedirectPC      registered one-cycle PC load request and target
//   Flush                    registered one-cycle pipeline flush
//   EXL                      Status.EXL
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Unimpl,
    input  logic        Sys,
    input  logic        Eret,
    input  logic        InstrValid,
    input  logic [31:0] ExcPCIn,
    input  logic        CPWr,
    input  logic [4:0]  CPWAddr,
    input  logic [31:0] CPWData,
    input  logic [4:0]  CPRAddr,
    output logic [31:0] CPRData,
    input  logic [5:0]  HWInt,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        Flush,
    output logic        EXL
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_PRID   = 5'd15;

    state_t      state;
    logic [5:0]  hw_meta;
    logic [5:0]  hw_sync;
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        in_run;
    logic        int_req;
    logic        exc_take;
    logic        eret_take;
    logic        wr_take;
    logic [4:0]  next_code;

    assign in_run  = (state == RUN);
    // Status is read pre-write, so an MTC0 in the same cycle cannot affect this.
    assign int_req = ie & ~exl & (|(hw_sync & im)) & InstrValid;

    assign exc_take  = in_run & InstrValid & (Unimpl | Sys | int_req);
    assign eret_take = in_run & ~exc_take & InstrValid & Eret & exl;
    // Events always win over a same-cycle MTC0; the write is dropped.
    assign wr_take   = in_run & CPWr & ~exc_take & ~eret_take;

    always_comb begin
        next_code = 5'd0;
        if (Unimpl)
            next_code = 5'd10;
        else if (Sys)
            next_code = 5'd8;
    end

    always_comb begin
        CPRData = 32'h0;
        case (CPRAddr)
            REG_STATUS: CPRData = {16'h0, im, 8'h0, exl, ie};
            REG_CAUSE:  CPRData = {16'h0, hw_sync, 3'b000, exc_code, 2'b00};
            REG_EPC:    CPRData = epc;
            REG_PRID:   CPRData = PRID_VAL;
            default:    CPRData = 32'h0;
        endcase
    end

    assign EXL = exl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            hw_meta    <= 6'h0;
            hw_sync    <= 6'h0;
            im         <= 6'h0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            exc_code   <= 5'd0;
            epc        <= 32'h0;
            Redirect   <= 1'b0;
            Flush      <= 1'b0;
            RedirectPC <= 32'h0;
        end else begin
            hw_meta    <= HWInt;
            hw_sync    <= hw_meta;
            Redirect   <= 1'b0;
            Flush      <= 1'b0;
            RedirectPC <= 32'h0;

            case (state)
                RUN: begin
                    if (exc_take) begin
                        epc        <= ExcPCIn;
                        exc_code   <= next_code;
                        exl        <= 1'b1;
                        state      <= FLUSH;
                        Redirect   <= 1'b1;
                        Flush      <= 1'b1;
                        RedirectPC <= EXC_VECTOR;
                    end else if (eret_take) begin
                        exl        <= 1'b0;
                        state      <= FLUSH;
                        Redirect   <= 1'b1;
                        Flush      <= 1'b1;
                        RedirectPC <= epc;
                    end else if (wr_take) begin
                        case (CPWAddr)
                            REG_STATUS: begin
                                im  <= CPWData[15:10];
                                exl <= CPWData[1];
                                ie  <= CPWData[0];
                            end
                            REG_EPC: epc <= CPWData;
                            default: ;
                        endcase
                    end
                end
                // Everything presented here is from wrong-path instructions.
                FLUSH: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the 5-stage MIPS pipeline. It consumes the exception and CP0 control signals produced by the main decoder (`Unimpl`, `Sys`, `CPWr`, ERET decode) and owns the Status, Cause, EPC and PRId registers. It arbitrates synchronous exceptions against external interrupts and serves MFC0 reads. On exception entry or ERET it issues a registered one-cycle PC redirect and pipeline flush.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0000_4180: handler entry address.
- `PRID_VAL`, default 32'h0000_0001: constant value returned for PRId.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Unimpl`  in  1  unimplemented instruction at the commit point.
- `Sys`  in  1  SYSCALL at the commit point.
- `Eret`  in  1  ERET at the commit point.
- `InstrValid`  in  1  commit slot holds a real, non-bubble instruction. All exception, interrupt and ERET inputs are qualified by it.
- `ExcPCIn`  in  32  PC of the instruction at the commit point.
- `CPWr`  in  1  MTC0 write enable.
- `CPWAddr`  in  5  MTC0 destination register number.
- `CPWData`  in  32  MTC0 write data.
- `CPRAddr`  in  5  MFC0 source register number.
- `CPRData`  out  32  combinational read data.
- `HWInt`  in  6  asynchronous external interrupt lines.
- `Redirect`  out  1  one-cycle pulse requesting a PC load.
- `RedirectPC`  out  32  target address, valid while `Redirect`=1.
- `Flush`  out  1  one-cycle pulse that resets IF/ID, ID/Ex and Ex/Me.
- `EXL`  out  1  Status.EXL.

## Operation
Registers and reset values (all outputs are 0 after reset):
- Status (reg 12): IM[15:10], EXL[1] and IE[0] are writable; all other bits read 0. Reset value 0.
- Cause (reg 13): IP[15:10] mirrors the synchronised `HWInt`; ExcCode[6:2] is written on exception entry; all other bits read 0. MTC0 to Cause is ignored. Reset value 0.
- EPC (reg 14): full 32 bits are writable by MTC0. Reset value 0.
- PRId (reg 15): reads `PRID_VAL`. Writes are ignored.
- Any other read address returns 0.

Interrupt input:
- `HWInt` passes through a 2-flop synchroniser. Synchroniser flops reset to 0.
- `IntReq` = IE & ~EXL & |(IP & IM) & InstrValid.

Event priority, evaluated only in RUN state, highest first:
1. Unimpl: ExcCode 10.
2. Sys: ExcCode 8.
3. IntReq: ExcCode 0.
4. Eret, only when EXL=1. ERET with EXL=0 is a no-op.

Exception entry (priorities 1–3) at the clock edge:
- EPC ← `ExcPCIn`.
- Cause.ExcCode ← the code above.
- EXL ← 1.
- Next state FLUSH, with `Redirect`=1, `Flush`=1, `RedirectPC`=`EXC_VECTOR`.

ERET at the clock edge:
- EXL ← 0.
- Next state FLUSH, with `RedirectPC` = the EPC value held at the edge.

MTC0:
- Applied at the edge when `CPWr`=1 and no exception or ERET is taken in the same cycle. If an exception or ERET is taken, the write is dropped.
- An interrupt evaluated in the same cycle as an MTC0 to Status uses the old Status value.

State machine:
- RUN → FLUSH on exception or ERET.
- FLUSH → RUN unconditionally after 1 cycle.
- In FLUSH, all event inputs and `CPWr` are ignored, because they come from wrong-path instructions.

## Timing
- Event sampled in cycle N. `Redirect`, `Flush`, `RedirectPC` and the updated registers are visible in cycle N+1.
- `Redirect` and `Flush` are registered outputs, high for exactly one cycle.
- Earliest next event is sampled in cycle N+2.
- An `HWInt` assertion is visible in Cause.IP 2 cycles later. It can cause an exception sample no earlier than that cycle.
- `CPRData` is combinational and reflects the register state of the current cycle. There is no read-during-write bypass; the new value is visible the cycle after the edge.
- `rst` asserted in any state, including FLUSH, returns the block to RUN with all registers 0 at the next edge. `Redirect` and `Flush` are low in the following cycle.
- Interrupt lines are level-sensitive. A line held high while EXL=1 is taken in the first RUN cycle after ERET clears EXL, provided IE=1 and IM enables it.

## Test plan
- Reset, then read registers 12/13/14 → all return 0; PRId returns 32'h0000_0001; `Redirect`=0.
- `Sys`=1, `InstrValid`=1, `ExcPCIn`=32'h3010 → next cycle: `Redirect`=1, `RedirectPC`=32'h4180, EPC=32'h3010, Cause[6:2]=8, EXL=1; `Redirect`=0 the cycle after.
- `Unimpl` and `Sys` in the same cycle at PC 32'h3020 → ExcCode=10 and EPC=32'h3020. Then `Sys` presented during the FLUSH cycle → ignored.
- Write Status=32'h0000_0401 via MTC0, then raise `HWInt[0]` → after 2 cycles Cause bit 10=1, and at the next valid instruction the exception is taken with ExcCode=0. With IE=0 instead → no redirect.
- ERET with EXL=1 and EPC=32'h3010 → `RedirectPC`=32'h3010 and EXL=0. ERET with EXL=0 → no redirect.
- MTC0 to EPC in the same cycle as `Unimpl` → write dropped and EPC=`ExcPCIn`. `rst` asserted during FLUSH → all outputs 0 in the following cycle.
